// File: rtl/toggle_hs_pkg.sv
// Shared definitions for the two-phase (toggle) handshake receiver and transmitter.
package toggle_hs_pkg;

   localparam int TOGGLE_HS_DATA_W = 8;

   typedef enum logic {
      IDLE = 1'b0,
      PEND = 1'b1
   } hs_state_e;

   // Pointer width for a power-of-two FIFO depth; never narrower than one bit.
   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/toggle_handshake_rx_if.sv
// Bundle of the toggle request side and the valid/ready stream side of the receiver.
// master: the sender plus downstream consumer; slave: the receiver itself.
interface toggle_handshake_rx_if
   import toggle_hs_pkg::*;
#(
   parameter int DATA_W = TOGGLE_HS_DATA_W,
   parameter int DEPTH  = 4
) ();

   logic                       req_t;
   logic [DATA_W-1:0]          data_in;
   logic                       ack_t;
   logic [DATA_W-1:0]          data_out;
   logic                       valid;
   logic                       ready;
   logic [$clog2(DEPTH+1)-1:0] count;
   logic                       proto_err;

   modport master (
      output req_t, data_in, ready,
      input  ack_t, data_out, valid, count, proto_err
   );

   modport slave (
      input  req_t, data_in, ready,
      output ack_t, data_out, valid, count, proto_err
   );

endinterface

// File: rtl/toggle_edge_detect.sv
// Turns a level toggle into a one-cycle pulse (inverse of a T flip-flop).
// Macro TOGGLE_RX_SYNC_EN: insert a two-flop synchronizer ahead of the decode
// for a toggle coming from another clock domain.
module toggle_edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic tog,
   output logic edge_pulse
);

   logic tog_s;
   logic prev_reg;

`ifdef TOGGLE_RX_SYNC_EN
   logic [1:0] sync_reg;

   // Two-flop synchronizer; cleared so a post-reset level of 1 still decodes as a toggle.
   always_ff @(posedge clk) begin
      if (rst) sync_reg <= 2'b00;
      else     sync_reg <= {sync_reg[0], tog};
   end

   assign tog_s = sync_reg[1];
`else
   assign tog_s = tog;
`endif

   // Previous sampled level of the toggle.
   always_ff @(posedge clk) begin
      if (rst) prev_reg <= 1'b0;
      else     prev_reg <= tog_s;
   end

   assign edge_pulse = tog_s ^ prev_reg;

endmodule

// File: rtl/toggle_handshake_rx.sv
// Receiving end of the toggle handshake: decodes req_t toggles, stores words in a
// small FIFO, returns a toggle on ack_t per accepted word and streams the words out.
// Macro TOGGLE_RX_SYNC_EN (in toggle_edge_detect): synchronize req_t before decode.
module toggle_handshake_rx
   import toggle_hs_pkg::*;
#(
   parameter int DATA_W = TOGGLE_HS_DATA_W,
   parameter int DEPTH  = 4
) (
   input logic                  clk,
   input logic                  rst,
   toggle_handshake_rx_if.slave bus
);

   localparam int PW = ptr_w(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PW-1:0]     wr_ptr_reg;
   logic [PW-1:0]     rd_ptr_reg;
   logic [CW-1:0]     count_reg;
   logic [DATA_W-1:0] hold_reg;
   logic              ack_reg;
   logic              err_reg;
   hs_state_e         state_reg;
   hs_state_e         state_next;

   logic              req_edge;
   logic              pop;
   logic              can_push;
   logic              push;
   logic              hold_load;
   logic              err_set;
   logic [DATA_W-1:0] push_data;

   toggle_edge_detect u_req_edge (
      .clk        (clk),
      .rst        (rst),
      .tog        (bus.req_t),
      .edge_pulse (req_edge)
   );

   // A full FIFO may still take a word in a cycle where the head leaves.
   assign pop      = (count_reg != '0) && bus.ready;
   assign can_push = (count_reg != FULL_COUNT) || pop;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   // Next state: park in PEND while a word waits for FIFO space.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (req_edge && !can_push) state_next = PEND;
         PEND:    if (can_push)              state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // FSM outputs: which word gets written, whether to park it, and protocol errors.
   always_comb begin
      push      = 1'b0;
      hold_load = 1'b0;
      err_set   = 1'b0;
      push_data = bus.data_in;
      case (state_reg)
         IDLE: begin
            if (req_edge) begin
               if (can_push) push      = 1'b1;
               else          hold_load = 1'b1;
            end
         end
         PEND: begin
            push_data = hold_reg;
            if (can_push) push    = 1'b1;
            // A new toggle before the pending word is acked is dropped.
            if (req_edge) err_set = 1'b1;
         end
         default: ;
      endcase
   end

   // Parked word while the FIFO is full.
   always_ff @(posedge clk) begin
      if (hold_load) hold_reg <= bus.data_in;
   end

   // FIFO storage write port.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_reg] <= push_data;
   end

   // Pointers and occupancy; pointers wrap naturally at the power-of-two depth.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
         if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
         case ({push, pop})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Acknowledge toggle flips once per accepted word; protocol error is sticky.
   always_ff @(posedge clk) begin
      if (rst) begin
         ack_reg <= 1'b0;
         err_reg <= 1'b0;
      end else begin
         ack_reg <= ack_reg ^ push;
         if (err_set) err_reg <= 1'b1;
      end
   end

   assign bus.ack_t     = ack_reg;
   assign bus.data_out  = mem[rd_ptr_reg];
   assign bus.valid     = (count_reg != '0);
   assign bus.count     = count_reg;
   assign bus.proto_err = err_reg;

endmodule

// File: tb/tb_toggle_handshake_rx.sv
// Directed self-checking bench for toggle_handshake_rx (DATA_W=8, DEPTH=4).
module tb_toggle_handshake_rx;

`ifdef TOGGLE_RX_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;
   logic exp_ack  = 1'b0;

   toggle_handshake_rx_if #(.DATA_W(8), .DEPTH(4)) bus ();

   toggle_handshake_rx #(.DATA_W(8), .DEPTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One sender transaction: new word, toggle, wait for the receive latency.
   task automatic send(input logic [7:0] d);
      bus.data_in = d;
      bus.req_t   = ~bus.req_t;
      $display("send word %02h at %0t", d, $time);
      repeat (LAT) tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      bus.req_t = 1'b0;
      bus.data_in = 8'h00;
      bus.ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_valid", bus.valid, 0);
      check("rst_count", bus.count, 0);
      check("rst_ack", bus.ack_t, 0);
      check("rst_err", bus.proto_err, 0);

      // Single word
      send(8'hA5);
      exp_ack = ~exp_ack;
      check("single_ack", bus.ack_t, exp_ack);
      check("single_valid", bus.valid, 1);
      check("single_data", bus.data_out, 8'hA5);
      check("single_count", bus.count, 1);
      bus.ready = 1'b1;
      tick();
      bus.ready = 1'b0;
      check("single_pop_count", bus.count, 0);
      check("single_pop_valid", bus.valid, 0);

      // Fill and stall: fifth word parks in PEND
      for (int i = 1; i <= 5; i++) begin
         send(8'(i));
         if (i <= 4) exp_ack = ~exp_ack;
         check("fill_ack", bus.ack_t, exp_ack);
         check("fill_count", bus.count, (i <= 4) ? i : 4);
      end
      check("fill_head", bus.data_out, 8'h01);
      bus.ready = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         check("drain_data", bus.data_out, k);
         tick();
         if (k == 1) begin
            exp_ack = ~exp_ack;
            check("pend_release_ack", bus.ack_t, exp_ack);
            check("pend_release_count", bus.count, 4);
         end
      end
      bus.ready = 1'b0;
      check("drain_count", bus.count, 0);
      check("drain_valid", bus.valid, 0);

      // Simultaneous push and pop at full
      for (int i = 8'h10; i <= 8'h13; i++) begin
         send(8'(i));
         exp_ack = ~exp_ack;
      end
      check("full_count", bus.count, 4);
      bus.data_in = 8'h14;
      bus.req_t = ~bus.req_t;
      $display("send word 14 with pop at %0t", $time);
      repeat (LAT - 1) tick();
      bus.ready = 1'b1;
      tick();
      bus.ready = 1'b0;
      exp_ack = ~exp_ack;
      check("pushpop_count", bus.count, 4);
      check("pushpop_ack", bus.ack_t, exp_ack);
      check("pushpop_head", bus.data_out, 8'h11);
      bus.ready = 1'b1;
      for (int k = 8'h11; k <= 8'h14; k++) begin
         check("pushpop_drain", bus.data_out, k);
         tick();
      end
      bus.ready = 1'b0;
      check("pushpop_empty", bus.valid, 0);
      check("no_err_yet", bus.proto_err, 0);

      // Protocol error: extra toggle while a word is pending
      for (int i = 8'h20; i <= 8'h23; i++) begin
         send(8'(i));
         exp_ack = ~exp_ack;
      end
      send(8'h24);
      check("pend_ack", bus.ack_t, exp_ack);
      send(8'h25);
      check("err_set", bus.proto_err, 1);
      check("err_count", bus.count, 4);
      check("err_ack", bus.ack_t, exp_ack);
      bus.ready = 1'b1;
      for (int k = 8'h20; k <= 8'h24; k++) begin
         check("err_drain", bus.data_out, k);
         tick();
         if (k == 8'h20) begin
            exp_ack = ~exp_ack;
            check("err_release_ack", bus.ack_t, exp_ack);
         end
      end
      check("err_empty", bus.valid, 0);
      check("err_sticky", bus.proto_err, 1);

      // Pointer wrap: stream ten words with ready held high
      for (int i = 0; i < 10; i++) begin
         send(8'(i));
         exp_ack = ~exp_ack;
         check("wrap_data", bus.data_out, i);
         check("wrap_count", bus.count, 1);
         check("wrap_ack", bus.ack_t, exp_ack);
      end
      tick();
      bus.ready = 1'b0;
      check("wrap_empty", bus.valid, 0);

      // Reset mid-operation with a word pending
      for (int i = 8'h30; i <= 8'h34; i++) send(8'(i));
      check("pre_rst_count", bus.count, 4);
      rst = 1'b1;
      bus.req_t = 1'b0;
      tick();
      rst = 1'b0;
      exp_ack = 1'b0;
      check("midrst_count", bus.count, 0);
      check("midrst_valid", bus.valid, 0);
      check("midrst_ack", bus.ack_t, 0);
      check("midrst_err", bus.proto_err, 0);
      repeat (LAT + 1) tick();
      check("midrst_idle_count", bus.count, 0);

      // req_t high out of reset counts as a toggle
      rst = 1'b1;
      bus.req_t = 1'b1;
      bus.data_in = 8'h77;
      tick();
      rst = 1'b0;
      $display("send word 77 out of reset at %0t", $time);
      repeat (LAT) tick();
      check("postrst_count", bus.count, 1);
      check("postrst_data", bus.data_out, 8'h77);
      check("postrst_ack", bus.ack_t, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
